// File: rtl/ibex_resp_pkg.sv
// Shared types and helpers for the Ibex data-port responder.
package ibex_resp_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // In range iff the address is at or above base and its word offset is below words.
  function automatic logic in_range(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] words);
    logic [31:0] offset;
    offset = addr - base;
    return (addr >= base) && ((offset >> 2) < words);
  endfunction

endpackage

// File: rtl/ibex_resp_delay_line.sv
// Fixed-depth response shift line; only the valid bits are cleared by reset.
module ibex_resp_delay_line
  import ibex_resp_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic  clk,
  input  logic  rst_n,
  input  resp_t d,
  output resp_t q
);

  logic [DEPTH-1:0] vld;
  logic [32:0]      pay [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
    end else begin
      vld[0] <= d.valid;
      for (int i = 1; i < DEPTH; i++) vld[i] <= vld[i-1];
    end
  end

  always_ff @(posedge clk) begin
    pay[0] <= {d.rdata, d.err};
    for (int i = 1; i < DEPTH; i++) pay[i] <= pay[i-1];
  end

  // Payload is not reset, so it is masked whenever the last stage is empty.
  always_comb begin
    q.valid = vld[DEPTH-1];
    q.rdata = vld[DEPTH-1] ? pay[DEPTH-1][32:1] : 32'h0;
    q.err   = vld[DEPTH-1] & pay[DEPTH-1][0];
  end

endmodule

// File: rtl/ibex_data_responder.sv
// Ibex req/gnt/rvalid scratchpad responder with in-order fixed-latency responses.
// Optional random grant stall when IBEX_RESP_STALL_EN is defined.
module ibex_data_responder
  import ibex_resp_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE       = 32'h0000_0000,
  parameter int unsigned MEM_WORDS       = 1024,
  parameter int unsigned READ_LATENCY    = 1,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic [3:0]  outstanding_o
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);
  localparam int unsigned CNT_W = 4;

  logic [31:0]      mem [MEM_WORDS];
  logic [31:0]      offset;
  logic [IDX_W-1:0] idx;
  logic             hit;
  logic             stall;
  logic             accept;
  logic [CNT_W-1:0] outstanding_q;
  resp_t            resp_in;
  resp_t            resp_out;

  assign offset = addr_i - ADDR_BASE;
  assign idx    = IDX_W'(offset >> 2);
  assign hit    = in_range(addr_i, ADDR_BASE, 32'(MEM_WORDS));

  // A response retiring this cycle frees a slot for a same-cycle grant.
  assign gnt_o  = req_i && ((outstanding_q < CNT_W'(MAX_OUTSTANDING)) || rvalid_o) && !stall;
  assign accept = gnt_o;

  always_ff @(posedge clk_i) begin
    if (accept && hit && we_i) begin
      for (int k = 0; k < 4; k++) begin
        if (be_i[k]) mem[idx][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
  end

  always_comb begin
    resp_in.valid = accept;
    resp_in.rdata = (hit && !we_i) ? mem[idx] : 32'h0;
    resp_in.err   = !hit;
  end

  ibex_resp_delay_line #(
    .DEPTH (READ_LATENCY)
  ) u_delay (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .d     (resp_in),
    .q     (resp_out)
  );

  assign rvalid_o = resp_out.valid;
  assign rdata_o  = resp_out.rdata;
  assign err_o    = resp_out.err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding_q <= '0;
    end else begin
      case ({accept, rvalid_o})
        2'b10:   outstanding_q <= outstanding_q + CNT_W'(1);
        2'b01:   outstanding_q <= outstanding_q - CNT_W'(1);
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

  assign outstanding_o = outstanding_q;

`ifdef IBEX_RESP_STALL_EN
  logic [15:0] lfsr;

  // Fibonacci LFSR, taps 16,14,13,11.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

endmodule

// File: tb/tb_ibex_data_responder.sv
// Scoreboard bench for ibex_data_responder: two instances with different latency/limit settings.
module tb_ibex_data_responder;

  localparam logic [31:0] A_BASE  = 32'h0000_1000;
  localparam int          A_WORDS = 16;
  localparam int          A_LAT   = 4;
  localparam int          A_MAX   = 3;
  localparam logic [31:0] B_BASE  = 32'h0000_0000;
  localparam int          B_WORDS = 16;
  localparam int          B_LAT   = 3;
  localparam int          B_MAX   = 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_na, a_req, a_gnt, a_we, a_rvalid, a_err;
  logic [3:0]  a_be, a_outst;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic        rst_nb, b_req, b_gnt, b_we, b_rvalid, b_err;
  logic [3:0]  b_be, b_outst;
  logic [31:0] b_addr, b_wdata, b_rdata;

  ibex_data_responder #(
    .ADDR_BASE(A_BASE), .MEM_WORDS(A_WORDS), .READ_LATENCY(A_LAT), .MAX_OUTSTANDING(A_MAX)
  ) u_dut_a (
    .clk_i(clk), .rst_ni(rst_na), .req_i(a_req), .gnt_o(a_gnt), .we_i(a_we), .be_i(a_be),
    .addr_i(a_addr), .wdata_i(a_wdata), .rvalid_o(a_rvalid), .rdata_o(a_rdata),
    .err_o(a_err), .outstanding_o(a_outst)
  );

  ibex_data_responder #(
    .ADDR_BASE(B_BASE), .MEM_WORDS(B_WORDS), .READ_LATENCY(B_LAT), .MAX_OUTSTANDING(B_MAX)
  ) u_dut_b (
    .clk_i(clk), .rst_ni(rst_nb), .req_i(b_req), .gnt_o(b_gnt), .we_i(b_we), .be_i(b_be),
    .addr_i(b_addr), .wdata_i(b_wdata), .rvalid_o(b_rvalid), .rdata_o(b_rdata),
    .err_o(b_err), .outstanding_o(b_outst)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  exp_t        qa[$];
  exp_t        qb[$];
  logic [31:0] ma [A_WORDS];
  logic [31:0] mb [B_WORDS];
  int          gcyc [6];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void flag(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endfunction

  // Reference behaviour: a plain word array, byte-lane merge, range test by arithmetic.
  function automatic exp_t model(input bit sel_b, input logic we, input logic [3:0] be,
                                 input logic [31:0] addr, input logic [31:0] wd);
    exp_t        e;
    longint      base, words, a, w;
    logic [31:0] cur;
    base  = sel_b ? longint'({32'h0, B_BASE}) : longint'({32'h0, A_BASE});
    words = sel_b ? longint'(B_WORDS) : longint'(A_WORDS);
    a     = longint'({32'h0, addr});
    e.rdata = 32'h0;
    e.err   = 1'b0;
    e.due   = 0;
    if (a < base || (a - base) / 4 >= words) begin
      e.err = 1'b1;
    end else begin
      w   = (a - base) / 4;
      cur = sel_b ? mb[w] : ma[w];
      if (we) begin
        for (int k = 0; k < 4; k++) if (be[k]) cur[8*k +: 8] = wd[8*k +: 8];
        if (sel_b) mb[w] = cur; else ma[w] = cur;
      end else begin
        e.rdata = cur;
      end
    end
    return e;
  endfunction

  // Monitor A: pops on rvalid, pushes on accept; in-flight count must equal queue depth.
  always @(negedge clk) begin
    exp_t e;
    logic allow;
    if (!rst_na) begin
      qa.delete();
      chk("a_rst_rvalid", 32'(a_rvalid), 32'h0);
      chk("a_rst_outstanding", 32'(a_outst), 32'h0);
      chk("a_rst_gnt", 32'(a_gnt), 32'h0);
    end else begin
      chk("a_outstanding", 32'(a_outst), 32'(qa.size()));
      allow = (qa.size() < A_MAX) || a_rvalid;
`ifdef IBEX_RESP_STALL_EN
      chk("a_gnt_legal", 32'(a_gnt & ~(a_req & allow)), 32'h0);
`else
      chk("a_gnt", 32'(a_gnt), 32'(a_req & allow));
`endif
      if (a_rvalid) begin
        if (qa.size() == 0) flag("a_spurious_rvalid");
        else begin
          e = qa.pop_front();
          chk("a_rdata", a_rdata, e.rdata);
          chk("a_err", 32'(a_err), 32'(e.err));
          chk("a_latency_cycle", 32'(cyc), 32'(e.due));
        end
      end else if (qa.size() != 0 && qa[0].due < cyc) begin
        void'(qa.pop_front());
        flag("a_missing_rvalid");
      end
      if (a_req && a_gnt) begin
        e = model(1'b0, a_we, a_be, a_addr, a_wdata);
        e.due = cyc + A_LAT;
        qa.push_back(e);
      end
    end
  end

  // Monitor B: same scoreboard discipline for the single-outstanding instance.
  always @(negedge clk) begin
    exp_t e;
    logic allow;
    if (!rst_nb) begin
      qb.delete();
      chk("b_rst_rvalid", 32'(b_rvalid), 32'h0);
    end else begin
      chk("b_outstanding", 32'(b_outst), 32'(qb.size()));
      allow = (qb.size() < B_MAX) || b_rvalid;
`ifdef IBEX_RESP_STALL_EN
      chk("b_gnt_legal", 32'(b_gnt & ~(b_req & allow)), 32'h0);
`else
      chk("b_gnt", 32'(b_gnt), 32'(b_req & allow));
`endif
      if (b_rvalid) begin
        if (qb.size() == 0) flag("b_spurious_rvalid");
        else begin
          e = qb.pop_front();
          chk("b_rdata", b_rdata, e.rdata);
          chk("b_err", 32'(b_err), 32'(e.err));
          chk("b_latency_cycle", 32'(cyc), 32'(e.due));
        end
      end else if (qb.size() != 0 && qb[0].due < cyc) begin
        void'(qb.pop_front());
        flag("b_missing_rvalid");
      end
      if (b_req && b_gnt) begin
        e = model(1'b1, b_we, b_be, b_addr, b_wdata);
        e.due = cyc + B_LAT;
        qb.push_back(e);
      end
    end
  end

  task automatic req_a(input logic we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wd);
    int t = 0;
    a_req = 1'b1; a_we = we; a_be = be; a_addr = addr; a_wdata = wd;
    do begin @(negedge clk); t++; end while (!a_gnt && t < 100);
    if (!a_gnt) flag("a_grant_timeout");
    @(posedge clk); #1;
  endtask

  task automatic req_b(input logic we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wd);
    int t = 0;
    b_req = 1'b1; b_we = we; b_be = be; b_addr = addr; b_wdata = wd;
    do begin @(negedge clk); t++; end while (!b_gnt && t < 100);
    if (!b_gnt) flag("b_grant_timeout");
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    a_req = 1'b0;
    b_req = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int          sel, t;
    logic [31:0] addr;
    rst_na = 1'b0; rst_nb = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_be = 4'h0; a_addr = 32'h0; a_wdata = 32'h0;
    b_req = 1'b0; b_we = 1'b0; b_be = 4'h0; b_addr = 32'h0; b_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    rst_na = 1'b1; rst_nb = 1'b1;

    for (int i = 0; i < A_WORDS; i++) req_a(1'b1, 4'hF, A_BASE + 32'(4 * i), $urandom);
    for (int i = 0; i < B_WORDS; i++) req_b(1'b1, 4'hF, B_BASE + 32'(4 * i), $urandom);
    idle(2);

    // Full write/read, partial byte write, out-of-range above and below the window.
    req_a(1'b1, 4'hF, A_BASE + 32'd4, 32'hDEAD_BEEF);
    req_a(1'b0, 4'h0, A_BASE + 32'd4, 32'h0);
    req_a(1'b1, 4'b0001, A_BASE + 32'd4, 32'h0000_00AA);
    req_a(1'b0, 4'h3, A_BASE + 32'd6, 32'h0);
    req_a(1'b1, 4'hF, A_BASE + 32'(4 * A_WORDS), 32'h1234_5678);
    req_a(1'b0, 4'hF, A_BASE + 32'(4 * A_WORDS), 32'h0);
    req_a(1'b0, 4'hF, A_BASE - 32'd4, 32'h0);
    req_a(1'b0, 4'hF, A_BASE + 32'(4 * (A_WORDS - 1)), 32'h0);
    req_a(1'b0, 4'hF, A_BASE + 32'd4, 32'h0);
    idle(8);

    for (int n = 0; n < 1000; n++) begin
      sel = $urandom_range(0, 19);
      if (sel < 16)      addr = A_BASE + 32'(4 * sel) + 32'($urandom_range(0, 3));
      else if (sel < 18) addr = A_BASE + 32'(4 * A_WORDS) + 32'(4 * $urandom_range(0, 7));
      else               addr = A_BASE - 32'(4 * $urandom_range(1, 4));
      if ($urandom_range(0, 9) == 0) idle($urandom_range(1, 3));
      if ($urandom_range(0, 9) == 0) begin
        a_req = 1'b1; a_we = 1'($urandom); a_be = 4'($urandom); a_addr = addr; a_wdata = $urandom;
        @(negedge clk); @(posedge clk); #1;
        a_req = 1'b0;
      end else begin
        req_a(1'($urandom), 4'($urandom), addr, $urandom);
      end
    end
    idle(10);

    // Reset with two reads in flight; memory must survive.
    req_a(1'b1, 4'hF, A_BASE + 32'd8, 32'hCAFE_F00D);
    idle(8);
    req_a(1'b0, 4'hF, A_BASE + 32'd4, 32'h0);
    req_a(1'b0, 4'hF, A_BASE + 32'd8, 32'h0);
    a_req = 1'b0;
    rst_na = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_na = 1'b1;
    idle(8);
    req_a(1'b0, 4'hF, A_BASE + 32'd4, 32'h0);
    req_a(1'b0, 4'hF, A_BASE + 32'd8, 32'h0);
    idle(8);

    // Six back-to-back reads with the request held high on the single-outstanding instance.
    b_req = 1'b1; b_we = 1'b0; b_be = 4'hF;
    for (int k = 0; k < 6; k++) begin
      b_addr = B_BASE + 32'(4 * k);
      t = 0;
      do begin @(negedge clk); t++; end while (!b_gnt && t < 100);
      if (!b_gnt) flag("b_burst_grant_timeout");
      gcyc[k] = cyc;
      @(posedge clk); #1;
    end
    b_req = 1'b0;
`ifndef IBEX_RESP_STALL_EN
    for (int k = 1; k < 6; k++) chk("b_gnt_spacing", 32'(gcyc[k] - gcyc[k-1]), 32'(B_LAT));
`endif

    t = 0;
    while ((qa.size() != 0 || qb.size() != 0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (qa.size() != 0 || qb.size() != 0) flag("drain_timeout");
    idle(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
